inst_rom_loader: RTL

Instruction-memory responder for the CPU core's fetch port. It answers `rom_ce`/`rom_addr` requests with 32-bit instruction words. It fills its word array from a byte-wide load stream that uses a valid/ready handshake. A small state machine holds the core in reset while a program is loaded, then releases it to run. It sits at SoC top level, between the core's `rom_*` pins and a host or UART byte source.

---
 rtl/inst_rom_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, filled from a byte-wide load stream.
// Holds the core in reset while a program loads, then releases it to run.
module inst_rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_ready_o,
  input  logic                  load_done_i,
  input  logic                  go_i,
  output logic                  cpu_rst_o,
  output logic [ADDR_WIDTH:0]   words_loaded_o,
  output logic                  overflow_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned WPTR_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t              state, state_next;
  logic [WPTR_W-1:0]   wptr, wptr_next;
  logic [1:0]          cnt, cnt_next;
  logic [23:0]         shift_buf, shift_buf_next;
  logic                overflow_next;
  logic                accept;
  logic                wr_en;
  logic [31:0]         wr_data;
  logic [31:0]         mem [DEPTH];
  logic                in_range;
  logic                unused_addr_bits;

  // Next-state, byte assembly and write decisions
  always_comb begin
    state_next     = state;
    wptr_next      = wptr;
    cnt_next       = cnt;
    shift_buf_next = shift_buf;
    overflow_next  = overflow_o;
    accept         = 1'b0;
    wr_en          = 1'b0;
    wr_data        = 32'h0;
    unique case (state)
      IDLE: begin
        if (load_start_i)  state_next = LOAD;
        else if (go_i)     state_next = RUN;
      end
      LOAD: begin
        accept = load_valid_i && load_ready_o;
        if (accept) begin
          shift_buf_next = {shift_buf[15:0], load_byte_i};
          cnt_next       = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (wptr[ADDR_WIDTH]) begin
              overflow_next = 1'b1;
            end else begin
              wr_en     = 1'b1;
              wr_data   = {shift_buf, load_byte_i};
              wptr_next = wptr + WPTR_W'(1);
            end
          end
        end
        if (load_done_i) state_next = FLUSH;
      end
      FLUSH: begin
        if (cnt != 2'd0) begin
          if (wptr[ADDR_WIDTH]) begin
            overflow_next = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wptr_next = wptr + WPTR_W'(1);
            unique case (cnt)
              2'd1:    wr_data = {shift_buf[7:0], 24'h0};
              2'd2:    wr_data = {shift_buf[15:0], 16'h0};
              default: wr_data = {shift_buf, 8'h0};
            endcase
          end
        end
        state_next = RUN;
      end
      RUN: begin
        if (load_start_i) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
    // A fresh load starts from an empty stream
    if (state_next == LOAD && state != LOAD) begin
      wptr_next      = '0;
      cnt_next       = 2'd0;
      shift_buf_next = 24'h0;
      overflow_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cpu_rst_o    <= 1'b1;
      load_ready_o <= 1'b0;
      wptr         <= '0;
      cnt          <= 2'd0;
      shift_buf    <= 24'h0;
      overflow_o   <= 1'b0;
    end else begin
      state        <= state_next;
      cpu_rst_o    <= (state_next != RUN);
      load_ready_o <= (state_next == LOAD);
      wptr         <= wptr_next;
      cnt          <= cnt_next;
      shift_buf    <= shift_buf_next;
      overflow_o   <= overflow_next;
    end
  end

  assign words_loaded_o = wptr;

  // Program storage deliberately survives reset
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  assign in_range         = (rom_addr_i[31:ADDR_WIDTH+2] == '0);
  assign rom_data_o       = (rom_ce_i && in_range) ? mem[rom_addr_i[ADDR_WIDTH+1:2]] : 32'h0;
  assign unused_addr_bits = ^rom_addr_i[1:0];

endmodule
